// File: rtl/pw_conv_feeder_pkg.sv
// Shared types for the pointwise-convolution stream: sequencer states and the
// beat entry carried by the feeder FIFO and consumed by the accumulator stage.
package pw_pkg;

  localparam int PW_DATA_W = 8;
  localparam int PW_ACC_W  = 32;
  localparam int PW_ADDR_W = 16;
  localparam int PW_CH_W   = 10;
  localparam int PW_PIX_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [PW_DATA_W-1:0] data;
    logic signed [PW_DATA_W-1:0] weight;
    logic signed [PW_ACC_W-1:0]  bias;
    logic                        first;
    logic                        last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/pw_conv_feeder_beat_fifo.sv
// Two-entry synchronous FIFO holding MAC beats; head is presented without a
// bubble and the occupancy is exported for the feeder's credit check.
module pw_beat_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem0;
  logic [W-1:0] r_mem1;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  // Guards make an upstream credit slip harmless instead of corrupting state.
  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0   <= '0;
      r_mem1   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr_ptr) r_mem1 <= i_data;
        else          r_mem0 <= i_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_data  = r_rd_ptr ? r_mem1 : r_mem0;
  assign o_count = r_count;

endmodule

// File: rtl/pw_conv_feeder.sv
// Walks pix x oc x ic for one pointwise layer, reads activation/weight/bias
// buffers and streams one beat per MAC through a credit-controlled FIFO.
module pw_conv_feeder
  import pw_pkg::*;
#(
  parameter int DATA_W = PW_DATA_W,
  parameter int ACC_W  = PW_ACC_W,
  parameter int ADDR_W = PW_ADDR_W,
  parameter int CH_W   = PW_CH_W,
  parameter int PIX_W  = PW_PIX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CH_W-1:0]          cfg_in_ch,
  input  logic [CH_W-1:0]          cfg_out_ch,
  input  logic [PIX_W-1:0]         cfg_num_pix,
  input  logic [ADDR_W-1:0]        cfg_act_base,
  input  logic [ADDR_W-1:0]        cfg_wgt_base,
  output logic                     busy,
  output logic                     done,
  output logic                     act_rd_en,
  output logic [ADDR_W-1:0]        act_rd_addr,
  input  logic signed [DATA_W-1:0] act_rd_data,
  output logic                     wgt_rd_en,
  output logic [ADDR_W-1:0]        wgt_rd_addr,
  input  logic signed [DATA_W-1:0] wgt_rd_data,
  output logic                     bias_rd_en,
  output logic [CH_W-1:0]          bias_rd_addr,
  input  logic signed [ACC_W-1:0]  bias_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic signed [DATA_W-1:0] out_weight,
  output logic signed [ACC_W-1:0]  out_bias,
  output logic                     out_first,
  output logic                     out_last,
  output logic [1:0]               o_dbg_state
);

  // Stream handshake: a beat transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid never drops and out_* never change
  // while a beat is waiting.

  state_t r_state;
  state_t w_state_nxt;

  logic [CH_W-1:0]   r_in_ch;
  logic [CH_W-1:0]   r_out_ch;
  logic [PIX_W-1:0]  r_num_pix;
  logic [ADDR_W-1:0] r_wgt_base;
  logic [CH_W-1:0]   r_ic;
  logic [CH_W-1:0]   r_oc;
  logic [PIX_W-1:0]  r_pix;
  logic [ADDR_W-1:0] r_act_row;
  logic [ADDR_W-1:0] r_act_addr;
  logic [ADDR_W-1:0] r_wgt_addr;
  logic              r_inflight;
  logic              r_first_d;
  logic              r_last_d;

  logic [1:0]        w_count;
  logic [2:0]        w_credit_use;
  logic              w_pop;
  logic              w_issue;
  logic              w_launch;
  logic              w_cfg_zero;
  logic              w_last_ic;
  logic              w_last_oc;
  logic              w_last_pix;
  logic              w_final;
  logic              w_drain_done;
  logic [ADDR_W-1:0] w_next_row;
  beat_t             w_push_beat;
  beat_t             w_head;

  assign w_pop        = out_valid && out_ready;
  assign w_credit_use = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == RUN) && (w_credit_use < 3'd2);
  assign w_launch     = (r_state == IDLE) && start;
  assign w_cfg_zero   = (cfg_in_ch == '0) || (cfg_out_ch == '0) || (cfg_num_pix == '0);

  assign w_last_ic  = (r_ic == r_in_ch - CH_W'(1));
  assign w_last_oc  = (r_oc == r_out_ch - CH_W'(1));
  assign w_last_pix = (r_pix == r_num_pix - PIX_W'(1));
  assign w_final    = w_last_ic && w_last_oc && w_last_pix;
  assign w_next_row = r_act_row + ADDR_W'(r_in_ch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_done = 1'b0;
    case (r_state)
      IDLE: begin
        // A degenerate layer goes straight to DRAIN so done still pulses once.
        if (start) w_state_nxt = w_cfg_zero ? DRAIN : RUN;
      end
      RUN: begin
        if (w_issue && w_final) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((w_count == 2'd0) && !r_inflight) begin
          w_drain_done = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ch    <= '0;
      r_out_ch   <= '0;
      r_num_pix  <= '0;
      r_wgt_base <= '0;
      r_ic       <= '0;
      r_oc       <= '0;
      r_pix      <= '0;
      r_act_row  <= '0;
      r_act_addr <= '0;
      r_wgt_addr <= '0;
    end else if (w_launch) begin
      r_in_ch    <= cfg_in_ch;
      r_out_ch   <= cfg_out_ch;
      r_num_pix  <= cfg_num_pix;
      r_wgt_base <= cfg_wgt_base;
      r_ic       <= '0;
      r_oc       <= '0;
      r_pix      <= '0;
      r_act_row  <= cfg_act_base;
      r_act_addr <= cfg_act_base;
      r_wgt_addr <= cfg_wgt_base;
    end else if (w_issue) begin
      if (!w_last_ic) begin
        r_ic       <= r_ic + CH_W'(1);
        r_act_addr <= r_act_addr + ADDR_W'(1);
        r_wgt_addr <= r_wgt_addr + ADDR_W'(1);
      end else begin
        r_ic <= '0;
        if (!w_last_oc) begin
          // Weights are contiguous across oc, activations rewind to the pixel row.
          r_oc       <= r_oc + CH_W'(1);
          r_act_addr <= r_act_row;
          r_wgt_addr <= r_wgt_addr + ADDR_W'(1);
        end else begin
          r_oc       <= '0;
          r_pix      <= r_pix + PIX_W'(1);
          r_act_row  <= w_next_row;
          r_act_addr <= w_next_row;
          r_wgt_addr <= r_wgt_base;
        end
      end
    end
  end

  // Flags ride alongside the read so they land in the FIFO with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_first_d  <= 1'b0;
      r_last_d   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_first_d <= (r_ic == '0);
        r_last_d  <= w_last_ic;
      end
    end
  end

  always_comb begin
    w_push_beat        = '0;
    w_push_beat.data   = act_rd_data;
    w_push_beat.weight = wgt_rd_data;
    w_push_beat.bias   = bias_rd_data;
    w_push_beat.first  = r_first_d;
    w_push_beat.last   = r_last_d;
  end

  pw_beat_fifo #(
    .W(BEAT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign act_rd_en    = w_issue;
  assign wgt_rd_en    = w_issue;
  assign bias_rd_en   = w_issue;
  assign act_rd_addr  = r_act_addr;
  assign wgt_rd_addr  = r_wgt_addr;
  assign bias_rd_addr = r_oc;

  assign out_valid  = (w_count != 2'd0);
  assign out_data   = w_head.data;
  assign out_weight = w_head.weight;
  assign out_bias   = w_head.bias;
  assign out_first  = w_head.first;
  assign out_last   = w_head.last;

  assign done        = w_drain_done;
  assign busy        = (r_state != IDLE) && !w_drain_done;
  assign o_dbg_state = r_state;

endmodule

// File: doc/pw_conv_feeder.md
# pw_conv_feeder

Sequencer that drives the pointwise-convolution MAC stream. For one layer it walks pixels × output channels × input channels, reads activations, weights and biases from single-port synchronous buffers with 1-cycle read latency, and emits one beat per MAC (activation, weight, bias, first/last input-channel flags) under a valid/ready handshake. It sits upstream of the 1×1 accumulator: its output stream is that block's input stream.

## Interface
- DATA_W, 8, activation/weight width (signed)
- ACC_W, 32, bias width (signed)
- ADDR_W, 16, buffer address width
- CH_W, 10, channel-count width
- PIX_W, 12, pixel-count width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle launch pulse; config sampled in the same cycle
- cfg_in_ch / cfg_out_ch  in  CH_W  input/output channel counts
- cfg_num_pix  in  PIX_W  pixel count
- cfg_act_base / cfg_wgt_base  in  ADDR_W  buffer base addresses
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle completion pulse
- act_rd_en, act_rd_addr  out  1, ADDR_W  activation read request
- act_rd_data  in  DATA_W  valid the cycle after act_rd_en
- wgt_rd_en, wgt_rd_addr / wgt_rd_data  out/in  1, ADDR_W / DATA_W  weight read port, same timing
- bias_rd_en, bias_rd_addr / bias_rd_data  out/in  1, CH_W / ACC_W  bias read port, same timing
- out_valid, out_ready  out, in  1  stream handshake
- out_data, out_weight  out  DATA_W  activation and weight of the beat
- out_bias  out  ACC_W  bias of the current output channel (every beat)
- out_first, out_last  out  1  beat is ic==0 / ic==cfg_in_ch-1

## Operation
- Loop order, outermost first: pix, oc, ic. Activations are channel-last.
- act addr = act_base + pix·in_ch + ic; wgt addr = wgt_base + oc·in_ch + ic; bias addr = oc.
- Addresses are formed by running row-base registers. act row base += in_ch per pixel. wgt row base += in_ch per oc and reloads to wgt_base per pixel. No multipliers. Addresses wrap modulo 2^ADDR_W.
- One issue asserts all three rd_en together. The three returned words plus the first/last flags are written as one entry into a 2-entry output FIFO.
- Credit rule: issue only if (fifo_count + inflight − pop_this_cycle) < 2, where pop = out_valid && out_ready. This sustains 1 beat/cycle with out_ready high and never overflows the FIFO.
- FSM:
  - IDLE: start with all counts nonzero → RUN. Start with any count zero → done pulse next cycle, no reads issued.
  - RUN: issue while credits allow. Issuing the final (pix, oc, ic) → DRAIN.
  - DRAIN: FIFO empty and nothing inflight → IDLE with done=1 for one cycle.
- start while busy is ignored. Config is latched at start; later cfg changes do not affect the run in progress.
- Beat order is strictly preserved. No beat is dropped or duplicated.

## Timing
- Reset values: busy=0, done=0, all rd_en=0, all addresses=0, out_valid=0, all out_* data and flags=0. FIFO is emptied and inflight is cleared.
- Reset mid-run aborts the run immediately. The next start begins clean.
- Start in cycle 0 → first rd_en in cycle 1 → read data captured into the FIFO at the end of cycle 2 → out_valid in cycle 3.
- With out_ready held high, beats are contiguous.
- out_* stay stable while out_valid && !out_ready.
- done is asserted in the cycle after the handshake of the final beat. busy falls in the same cycle.

## Structure
- Shared package pw_pkg holds: the state enum (IDLE, RUN, DRAIN) and the FIFO entry struct {data, weight, bias, first, last}. The accumulator stage reuses the same struct.
- One sub-module, pw_beat_fifo: 2-entry synchronous FIFO parameterised on entry width, exposing count.

## Test plan
- in_ch=3, out_ch=2, pix=1, bases 0, out_ready=1 → 6 contiguous beats. act addr 0,1,2,0,1,2; wgt addr 0–5; bias addr 0,0,0,1,1,1. first on beats 0 and 3; last on beats 2 and 5. First out_valid in cycle 3; done one cycle after beat 5.
- in_ch=2, out_ch=2, pix=2, act_base=0x100 → act addr 100,101,100,101,102,103,102,103; wgt addr restarts at 0 for pixel 1.
- Same as the first scenario with out_ready low for 5 cycles after beat 1 → at most 2 entries buffered; beats 2–5 delivered in order, no loss or duplicates; out_* stable while stalled.
- in_ch=1 → every beat has out_first=out_last=1. cfg_out_ch=0 → done the cycle after start; no rd_en ever asserted.
- Second start mid-run → ignored; beat count unchanged.
- rst_n low mid-run → all outputs return to reset values; a subsequent start produces the full correct sequence.
